// File: rtl/apb_slave_regfile.sv
// APB responder with a word-addressed register file and programmable wait states.
// Ports:
//   Hclk, Hreset     - clock (rising edge), async active-high reset
//   Pselx[2:0]       - one-hot peripheral select; bit SLAVE_ID selects this block
//   Penable, Pwrite  - APB enable phase, transfer direction (1 = write)
//   Paddr[31:0]      - byte address; Paddr[11:2] is the word index
//   Pwdata[31:0]     - write data
//   Prdata[31:0]     - registered read data, held between read transfers
//   Pready, Pslverr  - registered completion and error response
module apb_slave_regfile #(
  parameter int unsigned SLAVE_ID    = 0,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READY
  } state_t;

  state_t             state, state_d;
  logic               wr_q, wr_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [31:0]        prdata_d;
  logic               pready_d, pslverr_d;
  logic               mem_we_c;
  logic               sel_c;
  logic               err_c;
  logic [IDX_W-1:0]   idx_c;
  logic [31:0]        mem [DEPTH];

  // Address bits outside the word index and the other slaves' selects are don't-care.
  logic unused_c;
  assign unused_c = &{1'b0, Paddr[31:12], Paddr[1:0], Pselx};

  assign sel_c = Pselx[SLAVE_ID];
  assign idx_c = Paddr[IDX_W+1:2];
  // Full 10-bit index compared so aliases above DEPTH are flagged, not wrapped.
  assign err_c = ({1'b0, Paddr[11:2]} >= 11'(DEPTH));

  // State and registered outputs.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state   <= ST_IDLE;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      cnt     <= '0;
      Prdata  <= '0;
      Pready  <= 1'b0;
      Pslverr <= 1'b0;
    end else begin
      state   <= state_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      cnt     <= cnt_d;
      Prdata  <= prdata_d;
      Pready  <= pready_d;
      Pslverr <= pslverr_d;
    end
  end

  // Register file; commits only on a completing, error-free write.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we_c) begin
      mem[idx_q] <= Pwdata;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state;
    wr_d      = wr_q;
    err_d     = err_q;
    idx_d     = idx_q;
    cnt_d     = cnt;
    prdata_d  = Prdata;
    pready_d  = Pready;
    pslverr_d = Pslverr;
    mem_we_c  = 1'b0;

    case (state)
      ST_IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        // Setup phase only; a bare Penable here has no transfer context.
        if (sel_c && !Penable) begin
          wr_d  = Pwrite;
          idx_d = idx_c;
          err_d = err_c;
          if (!Pwrite) begin
            prdata_d = err_c ? '0 : mem[idx_c];
          end
          if (WAIT_STATES == 0) begin
            state_d   = ST_READY;
            pready_d  = 1'b1;
            pslverr_d = err_c;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES);
          end
        end
      end

      ST_WAIT: begin
        if (!sel_c) begin
          state_d   = ST_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (Penable) begin
          cnt_d = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_d   = ST_READY;
            pready_d  = 1'b1;
            pslverr_d = err_q;
          end
        end
      end

      ST_READY: begin
        if (!sel_c) begin
          state_d   = ST_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (Penable && Pready) begin
          mem_we_c  = wr_q && !err_q;
          state_d   = ST_IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: three instances on one APB bus with different select bits,
// depths and wait-state counts, checked against hand-computed values.
module tb_apb_slave_regfile;

  logic        Hclk;
  logic        Hreset;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  int n_vec;
  int n_miss;

  apb_slave_regfile #(.SLAVE_ID(0), .DEPTH(16), .WAIT_STATES(0)) u_s0 (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0]));

  apb_slave_regfile #(.SLAVE_ID(1), .DEPTH(16), .WAIT_STATES(3)) u_s1 (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1]));

  apb_slave_regfile #(.SLAVE_ID(2), .DEPTH(8), .WAIT_STATES(2)) u_s2 (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(prdata[2]), .Pready(pready[2]), .Pslverr(pslverr[2]));

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transfer starting in the current cycle (called just after a rising edge);
  // returns just after the completing edge so a following call is back to back.
  task automatic apb_xfer(input int s, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int nw,
                          input logic [31:0] exp_rd, input bit exp_err, input string tag);
    Pselx   = 3'(1 << s);
    Penable = 1'b0;
    Pwrite  = wr;
    Paddr   = addr;
    Pwdata  = wdata;
    @(posedge Hclk); #1;
    Penable = 1'b1;
    for (int k = 0; k <= nw; k++) begin
      @(negedge Hclk);
      check({tag, "_rdy"}, 32'(pready[s]), 32'(k == nw));
      if (k == nw) begin
        check({tag, "_err"}, 32'(pslverr[s]), 32'(exp_err));
        check({tag, "_rd"}, prdata[s], exp_rd);
      end
      @(posedge Hclk); #1;
    end
    Pselx   = 3'b000;
    Penable = 1'b0;
    Pwrite  = 1'b0;
  endtask

  task automatic idle_chk(input int s, input string tag);
    Pselx   = 3'b000;
    Penable = 1'b0;
    @(negedge Hclk);
    check({tag, "_rdy"}, 32'(pready[s]), 32'd0);
    check({tag, "_err"}, 32'(pslverr[s]), 32'd0);
    @(posedge Hclk); #1;
  endtask

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    Hreset  = 1'b1;
    Pselx   = 3'b000;
    Penable = 1'b0;
    Pwrite  = 1'b0;
    Paddr   = '0;
    Pwdata  = '0;
    repeat (2) @(posedge Hclk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst%0d_rd", s), prdata[s], 32'd0);
      check($sformatf("rst%0d_rdy", s), 32'(pready[s]), 32'd0);
      check($sformatf("rst%0d_err", s), 32'(pslverr[s]), 32'd0);
    end
    Hreset = 1'b0;

    // Zero-wait slave: basic read, write/read back to back, address aliasing.
    apb_xfer(0, 0, 32'h0000_000C, 32'h0, 0, 32'h0, 0, "rd_idx3");
    idle_chk(0, "idle_a");
    apb_xfer(0, 1, 32'h0000_0008, 32'hA5A5_1234, 0, 32'h0, 0, "wr_idx2");
    apb_xfer(0, 0, 32'h0000_0008, 32'h0, 0, 32'hA5A5_1234, 0, "rd_idx2");
    apb_xfer(0, 0, 32'h1000_0008, 32'h0, 0, 32'hA5A5_1234, 0, "rd_alias");

    // Depth boundary: last valid index, out-of-range write dropped, read returns 0.
    apb_xfer(0, 1, 32'h0000_0000, 32'h1111_2222, 0, 32'hA5A5_1234, 0, "wr_idx0");
    apb_xfer(0, 1, 32'h0000_003C, 32'hCAFE_F00D, 0, 32'hA5A5_1234, 0, "wr_idx15");
    apb_xfer(0, 1, 32'h0000_0040, 32'hFFFF_FFFF, 0, 32'hA5A5_1234, 1, "wr_oob");
    apb_xfer(0, 0, 32'h0000_0040, 32'h0, 0, 32'h0, 1, "rd_oob");
    idle_chk(0, "idle_b");
    apb_xfer(0, 0, 32'h0000_0000, 32'h0, 0, 32'h1111_2222, 0, "rd_idx0");
    apb_xfer(0, 0, 32'h0000_003C, 32'h0, 0, 32'hCAFE_F00D, 0, "rd_idx15");
    apb_xfer(0, 0, 32'h0000_0FFC, 32'h0, 0, 32'h0, 1, "rd_idx1023");

    // Three wait states: Pready low for three enable cycles, high on the fourth.
    apb_xfer(1, 1, 32'h0000_0004, 32'h0000_0055, 3, 32'h0, 0, "w3_wr");
    apb_xfer(1, 0, 32'h0000_0004, 32'h0, 3, 32'h0000_0055, 0, "w3_rd");

    // Two wait states, select dropped in the first enable cycle: no write.
    Pselx   = 3'b100;
    Pwrite  = 1'b1;
    Paddr   = 32'h0000_0010;
    Pwdata  = 32'h0000_0077;
    @(posedge Hclk); #1;
    Pselx   = 3'b000;
    Penable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Hclk);
      check($sformatf("w2_abort_rdy%0d", k), 32'(pready[2]), 32'd0);
      @(posedge Hclk); #1;
    end
    Penable = 1'b0;
    Pwrite  = 1'b0;
    apb_xfer(2, 0, 32'h0000_0010, 32'h0, 2, 32'h0, 0, "w2_rd_idx4");

    // Zero-wait slave aborted in the ready cycle: Pready clears, no write.
    Pselx   = 3'b001;
    Pwrite  = 1'b1;
    Paddr   = 32'h0000_000C;
    Pwdata  = 32'h0000_0BAD;
    @(posedge Hclk); #1;
    Pselx   = 3'b000;
    Penable = 1'b1;
    @(negedge Hclk);
    check("rdy_abort_hi", 32'(pready[0]), 32'd1);
    @(posedge Hclk); #1;
    @(negedge Hclk);
    check("rdy_abort_lo", 32'(pready[0]), 32'd0);
    @(posedge Hclk); #1;
    Penable = 1'b0;
    Pwrite  = 1'b0;
    apb_xfer(0, 0, 32'h0000_000C, 32'h0, 0, 32'h0, 0, "rd_after_abort");
    apb_xfer(0, 0, 32'h0000_0008, 32'h0, 0, 32'hA5A5_1234, 0, "rd_pre_rst");

    // Reset during the enable cycle of a write.
    Pselx   = 3'b001;
    Pwrite  = 1'b1;
    Paddr   = 32'h0000_0000;
    Pwdata  = 32'h0000_0099;
    @(posedge Hclk); #1;
    Penable = 1'b1;
    #1;
    check("rstw_rdy_before", 32'(pready[0]), 32'd1);
    Hreset = 1'b1;
    #1;
    check("rstw_rdy", 32'(pready[0]), 32'd0);
    check("rstw_err", 32'(pslverr[0]), 32'd0);
    check("rstw_rd", prdata[0], 32'd0);
    @(posedge Hclk); #1;
    Hreset  = 1'b0;
    Pselx   = 3'b000;
    Penable = 1'b0;
    Pwrite  = 1'b0;
    apb_xfer(0, 0, 32'h0000_0000, 32'h0, 0, 32'h0, 0, "rd_idx0_post_rst");
    apb_xfer(0, 0, 32'h0000_0008, 32'h0, 0, 32'h0, 0, "rd_idx2_post_rst");

    // Enable without a setup phase is ignored.
    Pselx   = 3'b001;
    Penable = 1'b1;
    Pwrite  = 1'b1;
    Paddr   = 32'h0000_0014;
    Pwdata  = 32'h0000_DEAD;
    for (int k = 0; k < 3; k++) begin
      @(negedge Hclk);
      check($sformatf("nosetup_rdy%0d", k), 32'(pready[0]), 32'd0);
      @(posedge Hclk); #1;
    end
    Pselx   = 3'b000;
    Penable = 1'b0;
    Pwrite  = 1'b0;
    apb_xfer(0, 0, 32'h0000_0014, 32'h0, 0, 32'h0, 0, "rd_idx5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
